bit_scan_encoder: RTL and testbench

Parametrised, sequential successor to the combinational 8-to-3 encoder.
- Accepts a WIDTH-bit active-high request vector through a valid/ready handshake and stores it.
- Emits the binary index of every set bit, one per accepted output beat, highest-first or lowest-first as selected per vector.
- Sits between request-generating logic (keypad/switch scanners, interrupt lines) and a consumer that services one index at a time, e.g. a seven-segment or bus driver.

---
 rtl/bit_scan_encoder.sv | 84 ++++++++
 tb/tb_bit_scan_encoder.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/bit_scan_encoder.sv
// Sequential bit-scan encoder: captures a request vector, then emits the index of
// each set bit one beat at a time, highest-first or lowest-first per vector.
module bit_scan_encoder #(
  parameter  int WIDTH = 8,
  localparam int IDXW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iValid,
  output logic             oReady,
  input  logic [WIDTH-1:0] iData,
  input  logic             iMode,
  output logic             oValid,
  input  logic             iReady,
  output logic [IDXW-1:0]  oData,
  output logic             oLast,
  output logic             oEmpty
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             mode_q;
  logic             empty_q;
  logic [IDXW-1:0]  idx;
  logic             one_hot;
  logic             scan;

  // Later loop iterations win, so loop order picks the end we scan from.
  always_comb begin
    idx = '0;
    if (mode_q) begin
      for (int i = WIDTH - 1; i >= 0; i--)
        if (pend_q[i]) idx = IDXW'(i);
    end else begin
      for (int i = 0; i < WIDTH; i++)
        if (pend_q[i]) idx = IDXW'(i);
    end
  end

  assign one_hot = (pend_q != '0) && ((pend_q & (pend_q - 1'b1)) == '0);
  assign pend_d  = pend_q & ~(WIDTH'(1) << idx);
  assign scan    = (state_q == SCAN);

  assign oReady = ~scan;
  assign oValid = scan;
  assign oData  = scan ? idx : '0;
  assign oLast  = scan & one_hot;
  assign oEmpty = empty_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      mode_q  <= 1'b0;
      empty_q <= 1'b0;
    end else begin
      empty_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (iValid) begin
            pend_q <= iData;
            mode_q <= iMode;
            if (iData == '0) empty_q <= 1'b1;
            else             state_q <= SCAN;
          end
        end
        SCAN: begin
          if (iReady) begin
            if (one_hot) begin
              pend_q  <= '0;
              state_q <= IDLE;
            end else begin
              pend_q  <= pend_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_scan_encoder.sv
// Directed bench for bit_scan_encoder: an 8-bit and a 16-bit instance side by side.
module tb_bit_scan_encoder;

  logic       clk = 1'b0;
  logic       rst;
  int         n_run = 0;
  int         n_fail = 0;

  logic       v8, rdy8, m8, ov8, ir8, last8, emp8;
  logic [7:0] d8;
  logic [2:0] od8;

  logic        v16, rdy16, m16, ov16, ir16, last16, emp16;
  logic [15:0] d16;
  logic [3:0]  od16;

  always #5 clk = ~clk;

  bit_scan_encoder #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .iValid(v8), .oReady(rdy8), .iData(d8), .iMode(m8),
    .oValid(ov8), .iReady(ir8), .oData(od8), .oLast(last8), .oEmpty(emp8)
  );

  bit_scan_encoder #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .iValid(v16), .oReady(rdy16), .iData(d16), .iMode(m16),
    .oValid(ov16), .iReady(ir16), .oData(od16), .oLast(last16), .oEmpty(emp16)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // Called at posedge+1; presents a vector for one cycle.
  task automatic accept8(input logic [7:0] data, input logic mode);
    v8 = 1'b1; d8 = data; m8 = mode;
    @(negedge clk); chk("acc_ready", rdy8, 1);
    @(posedge clk); #1;
    v8 = 1'b0;
  endtask

  task automatic beat8(input string tag, input int idx, input logic last);
    @(negedge clk);
    chk({tag, "_valid"}, ov8, 1);
    chk({tag, "_data"}, od8, idx);
    chk({tag, "_last"}, last8, last);
    @(posedge clk); #1;
  endtask

  task automatic idle8(input string tag);
    @(negedge clk);
    chk({tag, "_valid"}, ov8, 0);
    chk({tag, "_ready"}, rdy8, 1);
    chk({tag, "_data"}, od8, 0);
    chk({tag, "_last"}, last8, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; v8 = 0; d8 = 0; m8 = 0; ir8 = 1;
    v16 = 0; d16 = 0; m16 = 0; ir16 = 1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", rdy8, 1);
    chk("rst_valid", ov8, 0);
    chk("rst_data", od8, 0);
    chk("rst_last", last8, 0);
    chk("rst_empty", emp8, 0);
    @(posedge clk); #1;

    // 1: highest-first
    accept8(8'b1010_0110, 1'b0);
    beat8("t1b0", 7, 0); beat8("t1b1", 5, 0); beat8("t1b2", 2, 0); beat8("t1b3", 1, 1);
    idle8("t1_end");

    // 2: lowest-first
    accept8(8'b1010_0110, 1'b1);
    beat8("t2b0", 1, 0); beat8("t2b1", 2, 0); beat8("t2b2", 5, 0); beat8("t2b3", 7, 1);
    idle8("t2_end");

    // 3: zero vector, then a new vector accepted during the oEmpty cycle
    accept8(8'h00, 1'b0);
    v8 = 1'b1; d8 = 8'h02; m8 = 1'b1;
    @(negedge clk);
    chk("t3_empty", emp8, 1);
    chk("t3_valid", ov8, 0);
    chk("t3_ready", rdy8, 1);
    @(posedge clk); #1;
    v8 = 1'b0;
    beat8("t3b0", 1, 1);
    @(negedge clk);
    chk("t3_empty_gone", emp8, 0);
    chk("t3_valid_end", ov8, 0);
    @(posedge clk); #1;

    // 4: backpressure with iData toggling
    ir8 = 1'b0;
    accept8(8'h81, 1'b0);
    for (int i = 0; i < 3; i++) begin
      d8 = ~d8; m8 = ~m8; v8 = i[0];
      beat8("t4_hold", 7, 0);
    end
    v8 = 1'b0; ir8 = 1'b1;
    beat8("t4b0", 7, 0); beat8("t4b1", 0, 1);
    idle8("t4_end");
    chk("t4_empty", emp8, 0);

    // 5: reset mid-scan
    accept8(8'h0F, 1'b0);
    beat8("t5b0", 3, 0);
    rst = 1'b1;
    @(negedge clk); chk("t5_pre_rst", od8, 2);
    @(posedge clk); #1;
    rst = 1'b0;
    idle8("t5_rst");
    idle8("t5_rst2");
    accept8(8'h10, 1'b0);
    beat8("t5b1", 4, 1);
    idle8("t5_end");

    // 6: 16-bit instance
    v16 = 1'b1; d16 = 16'hFFFF; m16 = 1'b1;
    @(negedge clk); chk("t6_ready", rdy16, 1);
    @(posedge clk); #1;
    v16 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("t6_valid", ov16, 1);
      chk("t6_data", od16, i);
      chk("t6_last", last16, (i == 15) ? 1 : 0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("t6_end_valid", ov16, 0);
    chk("t6_end_ready", rdy16, 1);
    @(posedge clk); #1;
    v16 = 1'b1; d16 = 16'h8000; m16 = 1'b0;
    @(posedge clk); #1;
    v16 = 1'b0;
    @(negedge clk);
    chk("t6s_valid", ov16, 1);
    chk("t6s_data", od16, 15);
    chk("t6s_last", last16, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6s_end_valid", ov16, 0);
    chk("t6s_end_ready", rdy16, 1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
